// File: rtl/axi4lite_master_write_channel.sv
// -----------------------------------------------------------------------------
// axi4lite_master_write_channel
//
// AXI4-Lite master write channel. Accepts one single-beat write command at a
// time from a local requester, drives AW and W (independently, in any order),
// collects the B response and hands it back to the requester. Keeps a
// saturating count of non-OKAY responses.
//
// Ports
//   ACLK, ARESETN            clock (rising edge), async active-low reset
//   AW*  (AWVALID/AWREADY/AWADDR/AWPROT)   write address channel
//   W*   (WVALID/WREADY/WDATA/WSTRB)       write data channel
//   B*   (BVALID/BREADY/BRESP)             write response channel
//   iWriteAddress/Data/Strobe, iWriteValid, oWriteReady   command request
//   oWriteResp, oWriteRespValid, iWriteRespAck            response return
//   oErrorCount              saturating number of non-OKAY responses
//
// Every output is a decode of registered state, so no input reaches
// AWVALID, WVALID or BREADY combinationally.
// -----------------------------------------------------------------------------
module axi4lite_master_write_channel #(
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned ErrCountWidth = 16
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  output logic                       AWVALID,
  input  logic                       AWREADY,
  output logic [AddressWidth-1:0]    AWADDR,
  output logic [2:0]                 AWPROT,
  output logic                       WVALID,
  input  logic                       WREADY,
  output logic [DataWidth-1:0]       WDATA,
  output logic [DataWidth/8-1:0]     WSTRB,
  input  logic                       BVALID,
  output logic                       BREADY,
  input  logic [1:0]                 BRESP,
  input  logic [AddressWidth-1:0]    iWriteAddress,
  input  logic [DataWidth-1:0]       iWriteData,
  input  logic [DataWidth/8-1:0]     iWriteStrobe,
  input  logic                       iWriteValid,
  output logic                       oWriteReady,
  output logic [1:0]                 oWriteResp,
  output logic                       oWriteRespValid,
  input  logic                       iWriteRespAck,
  output logic [ErrCountWidth-1:0]   oErrorCount
);

  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_REPORT    = 2'd3
  } state_e;

  state_e                   state_q,   state_d;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q,  w_done_d;
  logic [AddressWidth-1:0]  addr_q,    addr_d;
  logic [DataWidth-1:0]     data_q,    data_d;
  logic [StrbWidth-1:0]     strb_q,    strb_d;
  logic [1:0]               resp_q,    resp_d;
  logic [ErrCountWidth-1:0] err_cnt_q, err_cnt_d;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ErrCountWidth-1:0] sat_inc(input logic [ErrCountWidth-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(ErrCountWidth-1){1'b0}}, 1'b1};
    end
  endfunction

  // Output decodes; valids fall as soon as their own handshake has been seen.
  assign AWVALID         = (state_q == ST_ISSUE) && !aw_done_q;
  assign WVALID          = (state_q == ST_ISSUE) && !w_done_q;
  assign BREADY          = (state_q == ST_WAIT_RESP);
  assign oWriteReady     = (state_q == ST_IDLE);
  assign oWriteRespValid = (state_q == ST_REPORT);
  assign AWADDR          = addr_q;
  assign WDATA           = data_q;
  assign WSTRB           = strb_q;
  assign AWPROT          = 3'b000;
  assign oWriteResp      = resp_q;
  assign oErrorCount     = err_cnt_q;

  // State, handshake flags, command latches, response and error counter.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= {AddressWidth{1'b0}};
      data_q    <= {DataWidth{1'b0}};
      strb_q    <= {StrbWidth{1'b0}};
      resp_q    <= 2'b00;
      err_cnt_q <= {ErrCountWidth{1'b0}};
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      resp_q    <= resp_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    resp_d    = resp_q;
    err_cnt_d = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (iWriteValid) begin
          addr_d    = iWriteAddress;
          data_d    = iWriteData;
          strb_d    = iWriteStrobe;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_ISSUE;
        end else begin
          state_d   = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        // Handshakes on this edge count, so both channels finishing in the
        // same cycle (or the second one finishing now) moves on immediately.
        aw_done_d = aw_done_q | (AWVALID & AWREADY);
        w_done_d  = w_done_q  | (WVALID  & WREADY);
        if (aw_done_d && w_done_d) begin
          state_d = ST_WAIT_RESP;
        end else begin
          state_d = ST_ISSUE;
        end
      end

      ST_WAIT_RESP: begin
        if (BVALID) begin
          resp_d  = BRESP;
          state_d = ST_REPORT;
          if (BRESP != 2'b00) begin
            err_cnt_d = sat_inc(err_cnt_q);
          end else begin
            err_cnt_d = err_cnt_q;
          end
        end else begin
          state_d = ST_WAIT_RESP;
        end
      end

      ST_REPORT: begin
        if (iWriteRespAck) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REPORT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
